// File: rtl/bgs_pkg.sv
// Shared types and helpers for the set-associative BTB with gshare direction predictor.
// Holds the BTB entry layout, PC decode, sweep FSM states and saturating counter arithmetic.
package bgs_pkg;

    typedef enum logic {CLEAR, READY} fsm_state_t;

    // Tag is stored zero-extended so one layout serves every TAG_BITS setting
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_way_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] tag;
    } btb_addr_t;

    function automatic btb_addr_t decode_pc(input logic [31:0] pc, input int set_bits,
                                            input int tag_bits);
        btb_addr_t a;
        logic [63:0] tag_mask;
        tag_mask = (64'd1 << tag_bits) - 64'd1;
        a.index  = (pc >> 2) & ((32'd1 << set_bits) - 32'd1);
        a.tag    = 32'((64'(pc) >> (set_bits + 2)) & tag_mask);
        return a;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic [31:0] max);
        return (c >= max) ? max : c + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] c);
        return (c == 32'd0) ? 32'd0 : c - 32'd1;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Gshare direction table and global history: zero-latency counter read, registered writes.
// No backpressure; sweep writes win over updates, repair wins over speculative shift.
module gshare_pht
    import bgs_pkg::*;
#(
    parameter int GHR_BITS  = 6,
    parameter int PRED_BITS = 2,
    parameter int CNT_W     = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                sweep,
    input  logic [CNT_W-1:0]    sweep_idx,
    input  logic [31:0]         lookup_pc,
    input  logic                spec_shift,
    input  logic                spec_bit,
    input  logic                upd_en,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                repair,
    output logic                pred_msb,
    output logic [GHR_BITS-1:0] ghr
);

    localparam int DEPTH = 1 << GHR_BITS;
    localparam logic [PRED_BITS-1:0] INIT    = PRED_BITS'((1 << (PRED_BITS - 1)) - 1);
    localparam logic [31:0]          CTR_MAX = 32'((64'd1 << PRED_BITS) - 64'd1);

    logic [PRED_BITS-1:0] pht [DEPTH];
    logic [GHR_BITS-1:0]  rd_idx;
    logic [GHR_BITS-1:0]  wr_idx;

    assign rd_idx   = ghr ^ GHR_BITS'(lookup_pc >> 2);
    assign wr_idx   = upd_ghr ^ GHR_BITS'(upd_pc >> 2);
    assign pred_msb = pht[rd_idx][PRED_BITS-1];

    // Repair rebuilds history from the snapshot the instruction carried
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= GHR_BITS'({upd_ghr, upd_taken});
        end else if (spec_shift) begin
            ghr <= GHR_BITS'({ghr, spec_bit});
        end
    end

    always_ff @(posedge clk) begin
        if (sweep) begin
            if (32'(sweep_idx) < DEPTH) begin
                pht[GHR_BITS'(sweep_idx)] <= INIT;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                pht[wr_idx] <= PRED_BITS'(sat_inc(32'(pht[wr_idx]), CTR_MAX));
            end else begin
                pht[wr_idx] <= PRED_BITS'(sat_dec(32'(pht[wr_idx])));
            end
        end
    end

endmodule

// File: rtl/btb_gshare_assoc.sv
// Set-associative BTB plus gshare predictor: combinational predict, one registered update per cycle.
// No backpressure; while busy (table sweep) predictions are not-taken and updates are dropped.
module btb_gshare_assoc
    import bgs_pkg::*;
#(
    parameter int N_SETS    = 16,
    parameter int ASSOC     = 2,
    parameter int TAG_BITS  = 8,
    parameter int GHR_BITS  = 6,
    parameter int PRED_BITS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         current_pc,
    input  logic                is_branch,
    input  logic                is_rv32c,
    output logic                predict_taken,
    output logic [31:0]         target_addr,
    output logic [GHR_BITS-1:0] ghr_snapshot,
    output logic                busy,
    input  logic                update_predictor,
    input  logic [31:0]         pc_to_update,
    input  logic                update_is_branch,
    input  logic                branch_result,
    input  logic [31:0]         update_addr,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                mispredict,
    input  logic                flush
);

    localparam int SET_BITS  = $clog2(N_SETS);
    localparam int IDX_W     = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int WAY_W     = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int PHT_DEPTH = 1 << GHR_BITS;
    localparam int SWEEP     = (N_SETS > PHT_DEPTH) ? N_SETS : PHT_DEPTH;
    localparam int CNT_W     = $clog2(SWEEP) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SWEEP - 1);

    fsm_state_t       state;
    logic [CNT_W-1:0] cnt;
    btb_way_t         btb        [N_SETS][ASSOC];
    logic [WAY_W-1:0] victim_ptr [N_SETS];

    btb_addr_t        rd_addr, wr_addr;
    logic [IDX_W-1:0] rd_set, wr_set;
    logic             rd_hit, wr_hit;
    logic [WAY_W-1:0] rd_way, wr_way;
    logic             pht_msb;
    logic             accept;

    assign busy    = (state == CLEAR);
    assign accept  = update_predictor && (state == READY) && !flush && !RST;
    assign rd_addr = decode_pc(current_pc, SET_BITS, TAG_BITS);
    assign wr_addr = decode_pc(pc_to_update, SET_BITS, TAG_BITS);
    assign rd_set  = IDX_W'(rd_addr.index);
    assign wr_set  = IDX_W'(wr_addr.index);

    // Fill overwrites a matching way, so at most one way can match here
    always_comb begin
        rd_hit = 1'b0;
        rd_way = '0;
        wr_hit = 1'b0;
        wr_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (btb[rd_set][w].valid && (btb[rd_set][w].tag == rd_addr.tag)) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(w);
            end
            if (btb[wr_set][w].valid && (btb[wr_set][w].tag == wr_addr.tag)) begin
                wr_hit = 1'b1;
                wr_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        predict_taken = 1'b0;
        if (!busy && rd_hit) begin
            predict_taken = is_branch ? pht_msb : 1'b1;
        end
        if (predict_taken) begin
            target_addr = btb[rd_set][rd_way].target;
        end else begin
            target_addr = current_pc + (is_rv32c ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (32'(cnt) < N_SETS) begin
                for (int w = 0; w < ASSOC; w++) begin
                    btb[IDX_W'(cnt)][w].valid <= 1'b0;
                end
                victim_ptr[IDX_W'(cnt)] <= '0;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= READY;
            end
        end else if (update_predictor) begin
            if (wr_hit) begin
                btb[wr_set][wr_way].target <= update_addr;
            end else begin
                btb[wr_set][victim_ptr[wr_set]] <= '{valid: 1'b1, tag: wr_addr.tag,
                                                     target: update_addr};
                victim_ptr[wr_set] <= WAY_W'((32'(victim_ptr[wr_set]) + 32'd1) % 32'(ASSOC));
            end
        end
    end

    gshare_pht #(
        .GHR_BITS  (GHR_BITS),
        .PRED_BITS (PRED_BITS),
        .CNT_W     (CNT_W)
    ) u_pht (
        .clk        (CLK),
        .rst        (RST),
        .restart    (flush),
        .sweep      (busy),
        .sweep_idx  (cnt),
        .lookup_pc  (current_pc),
        .spec_shift (is_branch && !busy),
        .spec_bit   (predict_taken),
        .upd_en     (accept && update_is_branch),
        .upd_pc     (pc_to_update),
        .upd_taken  (branch_result),
        .upd_ghr    (update_ghr),
        .repair     (accept && update_is_branch && mispredict),
        .pred_msb   (pht_msb),
        .ghr        (ghr_snapshot)
    );

endmodule
